// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment display source arbiter.
package seg_pkg;

    localparam int unsigned DATA_W  = 14;
    localparam int unsigned POINT_W = 4;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned HOLD_W  = 27;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // One display payload as carried on the shared datapath
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [POINT_W-1:0] point;
        logic               sign;
        logic               seg_en;
    } disp_t;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        idx2onehot = NUM_REQ'(1) << idx;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
        onehot2idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) onehot2idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/seg_src_arbiter_if.sv
// Requester-side bus and display-side outputs of the display source arbiter.
interface seg_src_arbiter_if;
    import seg_pkg::*;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  src_data;
    logic [NUM_REQ*POINT_W-1:0] src_point;
    logic [NUM_REQ-1:0]         src_sign;
    logic [NUM_REQ-1:0]         src_seg_en;
    logic [NUM_REQ-1:0]         gnt;
    logic [DATA_W-1:0]          data;
    logic [POINT_W-1:0]         point;
    logic                       sign;
    logic                       seg_en;

    modport master (
        output req, src_data, src_point, src_sign, src_seg_en,
        input  gnt, data, point, sign, seg_en
    );

    modport slave (
        input  req, src_data, src_point, src_sign, src_seg_en,
        output gnt, data, point, sign, seg_en
    );

endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin pick over three requesters, searching from last+1,
// optionally excluding one index (the current owner).
module rr_pick3
    import seg_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   start;
    logic [IDX_W-1:0]   pos;
    logic               found;

    always_comb begin
        cand  = req;
        if (excl_en) cand = cand & ~idx2onehot(excl_idx);
        start = (last >= IDX_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(start) + k) % NUM_REQ);
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/seg_src_arbiter.sv
// Shares one seven-segment display datapath among three requesters with
// round-robin arbitration and a minimum on-screen hold per grant.
module seg_src_arbiter
    import seg_pkg::*;
#(
    parameter logic [HOLD_W-1:0] HOLD_MAX = 27'd99_999_999
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    seg_src_arbiter_if.slave bus
);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   cur_q;
    logic [IDX_W-1:0]   last_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    disp_t              disp_q;
    disp_t              src_sel;

    logic               excl_en;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               cur_req;
    logic               hold_done;

    // While granted, last equals the owner, so the search starts just past it
    assign excl_en   = (state_q == ST_GRANT);
    assign cur_req   = bus.req[cur_q];
    assign hold_done = (hold_cnt_q == HOLD_MAX);

    rr_pick3 u_pick (
        .req      (bus.req),
        .last     (last_q),
        .excl_en  (excl_en),
        .excl_idx (cur_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        src_sel.data   = bus.src_data[32'(cur_q) * DATA_W +: DATA_W];
        src_sel.point  = bus.src_point[32'(cur_q) * POINT_W +: POINT_W];
        src_sel.sign   = bus.src_sign[cur_q];
        src_sel.seg_en = bus.src_seg_en[cur_q];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            cur_q      <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
            disp_q     <= '0;
        end else begin
            disp_q <= (state_q == ST_GRANT) ? src_sel : '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q    <= ST_GRANT;
                        gnt_q      <= idx2onehot(pick_idx);
                        cur_q      <= pick_idx;
                        last_q     <= pick_idx;
                        hold_cnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!cur_req && !pick_valid) begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        hold_cnt_q <= '0;
                    end else if ((!cur_req || hold_done) && pick_valid) begin
                        // Owner left or served its hold: hand over with no idle gap
                        gnt_q      <= idx2onehot(pick_idx);
                        cur_q      <= pick_idx;
                        last_q     <= pick_idx;
                        hold_cnt_q <= '0;
                    end else if (!hold_done) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.data   = disp_q.data;
    assign bus.point  = disp_q.point;
    assign bus.sign   = disp_q.sign;
    assign bus.seg_en = disp_q.seg_en;

endmodule

// File: tb/tb_seg_src_arbiter.sv
// Directed bench for seg_src_arbiter with a short hold (HOLD_MAX=7, 8-cycle grants).
module tb_seg_src_arbiter;
    import seg_pkg::*;

    localparam logic [DATA_W-1:0]  D0 = 14'd42;
    localparam logic [DATA_W-1:0]  D1 = 14'd1234;
    localparam logic [DATA_W-1:0]  D2 = 14'd9999;
    localparam logic [POINT_W-1:0] P0 = 4'b0001;
    localparam logic [POINT_W-1:0] P1 = 4'b0100;
    localparam logic [POINT_W-1:0] P2 = 4'b1000;
    localparam logic               S0 = 1'b1;
    localparam logic               S1 = 1'b0;
    localparam logic               S2 = 1'b1;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seg_src_arbiter_if bus ();

    seg_src_arbiter #(.HOLD_MAX(27'd7)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g, input logic [DATA_W-1:0] d,
                           input logic [POINT_W-1:0] p, input logic s, input logic e);
        chk({tag, ".gnt"},    32'(bus.gnt),    32'(g));
        chk({tag, ".data"},   32'(bus.data),   32'(d));
        chk({tag, ".point"},  32'(bus.point),  32'(p));
        chk({tag, ".sign"},   32'(bus.sign),   32'(s));
        chk({tag, ".seg_en"}, 32'(bus.seg_en), 32'(e));
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.req        = '0;
        bus.src_data   = {D2, D1, D0};
        bus.src_point  = {P2, P1, P0};
        bus.src_sign   = {S2, S1, S0};
        bus.src_seg_en = 3'b111;

        // 1: reset, then idle with no requests
        step(); chk_all("t1_rst0", 3'b000, '0, '0, 1'b0, 1'b0);
        step(); chk_all("t1_rst1", 3'b000, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (20) begin
            step(); chk_all("t1_idle", 3'b000, '0, '0, 1'b0, 1'b0);
        end

        // 2: lone requester 1
        bus.req = 3'b010;
        step(); chk_all("t2_c1", 3'b010, '0, '0, 1'b0, 1'b0);
        step(); chk_all("t2_c2", 3'b010, D1, P1, S1, 1'b1);
        repeat (48) step();
        chk_all("t2_c50", 3'b010, D1, P1, S1, 1'b1);

        // 3: req 0 and 2 alternate every 8 cycles
        rst = 1'b1; bus.req = 3'b000;
        step(); chk_all("t3_rst", 3'b000, '0, '0, 1'b0, 1'b0);
        rst = 1'b0; bus.req = 3'b101;
        step(); chk_all("t3_c1", 3'b001, '0, '0, 1'b0, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step(); chk_all("t3_own0", 3'b001, D0, P0, S0, 1'b1);
        end
        step(); chk_all("t3_c9", 3'b100, D0, P0, S0, 1'b1);
        step(); chk_all("t3_c10", 3'b100, D2, P2, S2, 1'b1);
        repeat (6) begin
            step(); chk("t3_own2", 32'(bus.gnt), 32'(3'b100));
        end
        step(); chk("t3_c17", 32'(bus.gnt), 32'(3'b001));
        repeat (7) begin
            step(); chk("t3_own0b", 32'(bus.gnt), 32'(3'b001));
        end
        step(); chk("t3_c25", 32'(bus.gnt), 32'(3'b100));

        // 4: owner 0 drops at hold_cnt=3, req2 takes over with a fresh hold
        rst = 1'b1; bus.req = 3'b000;
        step();
        rst = 1'b0; bus.req = 3'b101;
        step(); chk("t4_c1", 32'(bus.gnt), 32'(3'b001));
        repeat (3) step();
        bus.req = 3'b100;
        step(); chk("t4_c5", 32'(bus.gnt), 32'(3'b100));
        bus.req = 3'b101;
        repeat (7) begin
            step(); chk("t4_hold2", 32'(bus.gnt), 32'(3'b100));
        end
        step(); chk("t4_c13", 32'(bus.gnt), 32'(3'b001));

        // 5: everything drops; outputs clear one edge after the grant
        bus.req = 3'b000;
        step(); chk_all("t5_c14", 3'b000, D0, P0, S0, 1'b1);
        step(); chk_all("t5_c15", 3'b000, '0, '0, 1'b0, 1'b0);
        step(); chk_all("t5_c16", 3'b000, '0, '0, 1'b0, 1'b0);

        // 6: reset pulse mid-grant, then round robin restarts at 0
        bus.req = 3'b100;
        step(); chk("t6_gnt2", 32'(bus.gnt), 32'(3'b100));
        bus.req = 3'b111;
        step(); chk_all("t6_own2", 3'b100, D2, P2, S2, 1'b1);
        rst = 1'b1;
        step(); chk_all("t6_rst", 3'b000, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk_all("t6_rel", 3'b001, '0, '0, 1'b0, 1'b0);
        step(); chk_all("t6_out0", 3'b001, D0, P0, S0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
